// File: rtl/hams_merge2_if.sv
// Stream bundle for the two-way merge stage: two sorted input runs (a, b)
// and one merged output stream, all ready/valid.
interface hams_merge2_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  a_valid;
  logic                  a_ready;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] out_data;

  // master drives the input runs and consumes the merged stream
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/hams_merge2.sv
// Streaming two-way merge of two ascending runs of run_len elements into one
// ascending run of 2*run_len elements, with a single output register stage.
module hams_merge2 #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_RUN    = 1024,
  parameter int RUN_W      = $clog2(MAX_RUN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             unsigned_cmp,
  input  logic             start,
  input  logic [RUN_W-1:0] run_len,
  output logic             busy,
  output logic             done,
  hams_merge2_if.slave     s
);

  typedef enum logic [1:0] {IDLE, MERGE, DRAIN_A, DRAIN_B} state_t;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] len, cnt_a, cnt_b;
  logic             load_ok, a_le_b, a_final, b_final;
  logic             take_a, take_b, last;

  assign load_ok = !s.out_valid || s.out_ready;
  assign a_final = (cnt_a == len - RUN_W'(1));
  assign b_final = (cnt_b == len - RUN_W'(1));

  // ties resolve to A so equal keys keep their A-before-B order
  always_comb begin
    if (unsigned_cmp) a_le_b = (s.a_data <= s.b_data);
    else              a_le_b = ($signed(s.a_data) <= $signed(s.b_data));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_a    = 1'b0;
    take_b    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start && run_len != '0) state_nxt = MERGE;
      end
      MERGE: begin
        if (s.a_valid && s.b_valid && load_ok) begin
          take_a = a_le_b;
          take_b = !a_le_b;
          if (take_a && a_final)      state_nxt = DRAIN_B;
          else if (take_b && b_final) state_nxt = DRAIN_A;
        end
      end
      DRAIN_A: begin
        take_a = s.a_valid && load_ok;
        if (take_a && a_final) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN_B: begin
        take_b = s.b_valid && load_ok;
        if (take_b && b_final) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s.a_ready = take_a;
  assign s.b_ready = take_b;
  assign busy      = (state != IDLE);

  // the final element always lands in a drain state, so the total count is never stored
  always_ff @(posedge clk) begin
    if (rst) begin
      len   <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      done  <= 1'b0;
    end else begin
      done <= last || (state == IDLE && start && run_len == '0);
      if (state == IDLE && start && run_len != '0) begin
        len   <= run_len;
        cnt_a <= '0;
        cnt_b <= '0;
      end
      if (take_a) cnt_a <= cnt_a + RUN_W'(1);
      if (take_b) cnt_b <= cnt_b + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_last  <= 1'b0;
    end else if (take_a || take_b) begin
      s.out_valid <= 1'b1;
      s.out_data  <= take_a ? s.a_data : s.b_data;
      s.out_last  <= last;
    end else if (load_ok) begin
      s.out_valid <= 1'b0;
      s.out_last  <= 1'b0;
    end
  end

endmodule
